gearbox_wide_to_narrow: RTL and testbench
=========================================

# gearbox_wide_to_narrow

Parametrised wide-to-narrow width converter with AXI-Stream-style valid/ready on both sides, carrying byte-keep and packet-last sideband. It sits between the wide crypto/FIFO datapath and narrow DMA or stream ports, and is the generalised successor to the fixed 128→32 converter. It adds:
- configurable widths and lane order;
- registered outputs, with no combinational data path from input to output;
- full-throughput back-to-back operation;
- last-word lane trimming.

## Interface
Parameters:
- IN_W, 128, input data width in bits. Must be an integer multiple of OUT_W.
- OUT_W, 32, output data width in bits. Multiple of 8.
- MSB_FIRST, 0, lane emission order. 0 = lane 0 is the lowest slice; 1 = lane 0 is the highest slice.
- Derived values: RATIO = IN_W/OUT_W (≥2), IKW = IN_W/8, OKW = OUT_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  IN_W  input word
- s_keep  in  IKW  input byte enables
- s_last  in  1  input word is the final word of its packet
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- m_data  out  OUT_W  output lane
- m_keep  out  OKW  output byte enables
- m_last  out  1  final lane of the packet
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- busy  out  1  a word is held in the buffer

## Operation
Internal state:
- one IN_W word buffer, plus its keep and last bits;
- `full` flag;
- lane index `idx` (clog2(RATIO) bits);
- final lane index `fin`.

Lane mapping, for emission lane k:
- MSB_FIRST=0: data is s_data[k*OUT_W +: OUT_W]; keep is s_keep[k*OKW +: OKW].
- MSB_FIRST=1: slice index is RATIO-1-k.

Word accept:
- A word is accepted when s_valid && s_ready.
- The buffer loads, full←1, idx←0.
- fin←RATIO-1, except when trimmed (see Configuration).

Lane transfer (m_valid && m_ready):
- If idx≠fin: idx←idx+1.
- If idx==fin and a word is accepted in the same cycle: the new word loads. This is the back-to-back case.
- If idx==fin and no word is accepted: full←0.

Outputs:
- s_ready = !full || (m_ready && idx==fin). This is combinational from registered state and m_ready only.
- m_valid = full.
- m_data and m_keep = lane idx of the buffer. This is a mux from registers only.
- m_last = buf_last && idx==fin.
- busy = full.

Stall and sideband rules:
- m_ready low holds m_data, m_keep and m_last stable while m_valid is high.
- When m_valid is low, m_data and m_keep hold their last value.
- Lanes of non-last words are always emitted, even when their keep is zero.

## Timing
Reset values:
- m_valid=0, m_data=0, m_keep=0, m_last=0, busy=0.
- s_ready=1, because full=0. Upstream must hold s_valid low during reset.

Latency: a word accepted at edge N presents lane 0 after edge N, i.e. m_valid is high in cycle N+1.

Throughput:
- RATIO output beats per untrimmed word.
- No bubble between words when s_valid and m_ready are held high.

Reset mid-word: the buffer is dropped and the block returns to empty. No partial lanes are emitted after reset is released.

Simultaneous final-lane transfer and new accept: the new lane 0 appears in the next cycle, and m_valid stays high.

## Configuration
Macro: GBX_KEEP_TRIM_EN.

With GBX_KEEP_TRIM_EN defined, when a word is accepted with s_last=1:
- fin = the highest emission lane whose keep slice is nonzero.
- Trailing all-zero lanes are not emitted.
- If s_keep is all zero, fin=0. One beat is emitted with m_keep=0 and m_last=1, preserving the packet boundary.

Without GBX_KEEP_TRIM_EN: fin is always RATIO-1. Every word emits RATIO beats, and m_last is on the final lane.

## Test plan
1. **Single word, defaults.** s_data=0x44444444_33333333_22222222_11111111, s_keep=all ones, s_last=1, m_ready=1.
   - Required: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 in cycles N+1..N+4.
   - m_last only on the fourth beat; s_ready low in cycles N+1..N+3.
2. **Back-to-back words.** Three words with s_valid and m_ready held high.
   - Required: 12 consecutive beats with no m_valid gap; s_ready high exactly in the final-lane cycles.
3. **Backpressure.** m_ready toggles 1,0,0,1,… during a word.
   - Required: m_data, m_keep and m_last are stable while stalled; no lane is lost or duplicated; idx advances only on transfers.
4. **Lane order.** MSB_FIRST=1, same word as test 1.
   - Required: beat order 0x44444444, 0x33333333, 0x22222222, 0x11111111.
5. **Trim, with GBX_KEEP_TRIM_EN.** Last word with s_keep=0x00FF.
   - Required: two beats only, the second with m_last=1 and m_keep=0xF.
   - s_keep=0x0000 with s_last=1: one beat with m_keep=0 and m_last=1.
   - Without the macro: four beats, m_last on beat 4.
6. **Reset mid-word.** Assert rst_n low after beat 2 of 4.
   - Required: m_valid=0 and busy=0 immediately, s_ready=1.
   - The next word after reset starts at lane 0.

Source files
------------

// File: rtl/gearbox_wide_to_narrow.sv
// gearbox_wide_to_narrow: buffered IN_W->OUT_W lane splitter with keep/last sideband; define GBX_KEEP_TRIM_EN to drop trailing empty lanes of last words.
module gearbox_wide_to_narrow #(
  parameter int IN_W      = 128,
  parameter int OUT_W     = 32,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      s_data,
  input  logic [IN_W/8-1:0]    s_keep,
  input  logic                 s_last,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [OUT_W-1:0]     m_data,
  output logic [OUT_W/8-1:0]   m_keep,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int IKW = IN_W / 8;
  localparam int OKW = OUT_W / 8;
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);
  logic [IN_W-1:0] buf_data;
  logic [IKW-1:0] buf_keep;
  logic buf_last, full, last_lane, acc;
  logic [IW-1:0] idx, fin, new_fin, sel;
  assign sel = (MSB_FIRST != 0) ? LAST - idx : idx;
  assign last_lane = idx == fin;
  assign s_ready = !full || (m_ready && last_lane);
  assign acc = s_valid && s_ready;
  assign m_valid = full;
  assign busy = full;
  assign m_data = buf_data[sel*OUT_W +: OUT_W];
  assign m_keep = buf_keep[sel*OKW +: OKW];
  assign m_last = buf_last && last_lane;
`ifdef GBX_KEEP_TRIM_EN
  logic [IW-1:0] trim_fin;
  always_comb begin
    trim_fin = '0;
    for (int k = 0; k < RATIO; k++)
      if (|s_keep[((MSB_FIRST != 0) ? RATIO-1-k : k)*OKW +: OKW]) trim_fin = IW'(k);
  end
  assign new_fin = s_last ? trim_fin : LAST;
`else
  assign new_fin = LAST;
`endif
  // Buffer is kept after the last lane so the outputs hold their final value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_keep <= '0;
      buf_last <= 1'b0;
      full <= 1'b0;
      idx <= '0;
      fin <= '0;
    end else if (acc) begin
      buf_data <= s_data;
      buf_keep <= s_keep;
      buf_last <= s_last;
      full <= 1'b1;
      idx <= '0;
      fin <= new_fin;
    end else if (full && m_ready) begin
      if (last_lane) full <= 1'b0;
      else idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_gearbox_wide_to_narrow.sv
// tb_gearbox_wide_to_narrow: scoreboard bench for both lane orders; honours GBX_KEEP_TRIM_EN.
module tb_gearbox_wide_to_narrow;
  typedef struct {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  logic clk = 0, rst_n = 0;
  logic [127:0] s_data = '0;
  logic [15:0] s_keep = '0;
  logic s_last = 0, s_valid = 0, m_ready = 1, sel_msb = 0;
  logic a_ready, a_last, a_valid, a_busy, b_ready, b_last, b_valid, b_busy;
  logic [31:0] a_data, b_data;
  logic [3:0] a_keep, b_keep;
  logic o_ready, o_last, o_valid, o_busy;
  logic [31:0] o_data;
  logic [3:0] o_keep;
  beat_t q[$];
  int n_checks = 0, n_err = 0, beats_seen = 0;
  logic stall_prev = 0, p_last;
  logic [31:0] p_data;
  logic [3:0] p_keep;
  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  always #5 clk = ~clk;
  gearbox_wide_to_narrow u_lsb (.clk(clk), .rst_n(rst_n), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_valid(s_valid && !sel_msb), .s_ready(a_ready), .m_data(a_data),
    .m_keep(a_keep), .m_last(a_last), .m_valid(a_valid), .m_ready(m_ready), .busy(a_busy));
  gearbox_wide_to_narrow #(.MSB_FIRST(1)) u_msb (.clk(clk), .rst_n(rst_n), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid && sel_msb), .s_ready(b_ready),
    .m_data(b_data), .m_keep(b_keep), .m_last(b_last), .m_valid(b_valid), .m_ready(m_ready),
    .busy(b_busy));
  assign o_ready = sel_msb ? b_ready : a_ready;
  assign o_data = sel_msb ? b_data : a_data;
  assign o_keep = sel_msb ? b_keep : a_keep;
  assign o_last = sel_msb ? b_last : a_last;
  assign o_valid = sel_msb ? b_valid : a_valid;
  assign o_busy = sel_msb ? b_busy : a_busy;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push_word(input logic [127:0] d, input logic [15:0] k, input logic l, input logic msb);
    int fin, s;
    fin = 3;
`ifdef GBX_KEEP_TRIM_EN
    if (l) begin
      fin = 0;
      for (int j = 0; j < 4; j++) begin
        s = msb ? 3 - j : j;
        if (k[s*4 +: 4] != 0) fin = j;
      end
    end
`endif
    for (int j = 0; j <= fin; j++) begin
      s = msb ? 3 - j : j;
      q.push_back('{d[s*32 +: 32], k[s*4 +: 4], l && (j == fin)});
    end
  endtask
  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int n;
    s_data = d; s_keep = k; s_last = l; s_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 200);
    if (!o_ready) chk("send_timeout", 0, 1);
    else push_word(d, k, l, sel_msb);
    @(posedge clk) #1;
    s_valid = 0;
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 0);
    @(posedge clk) #1;
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && o_valid) begin
        chk("stall_data", o_data, p_data);
        chk("stall_keep", o_keep, p_keep);
        chk("stall_last", o_last, p_last);
      end
      stall_prev = o_valid && !m_ready;
      p_data = o_data; p_keep = o_keep; p_last = o_last;
      if (o_valid && m_ready) begin
        if (q.size() == 0) chk("extra_beat", o_data, 0);
        else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", o_data, e.d);
          chk("beat_keep", o_keep, e.k);
          chk("beat_last", o_last, e.l);
        end
        beats_seen++;
      end
    end else stall_prev = 0;
  end
  initial begin
    int b0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_keep", o_keep, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 1);
    rst_n = 1;
    @(posedge clk) #1;
    send(W1, 16'hFFFF, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", o_valid, 1);
      chk("t1_sready", o_ready, i == 3);
      chk("t1_last", o_last, i == 3);
    end
    @(negedge clk);
    chk("t1_idle", o_valid, 0);
    @(posedge clk) #1;
    send(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 16'hFFFF, 0);
    fork
      begin
        send(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 16'h0F0F, 0);
        send(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 16'hFFFF, 1);
      end
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk("b2b_valid", o_valid, 1);
        chk("b2b_sready", o_ready, (i % 4) == 3);
      end
    join
    drain();
    fork
      send(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 16'hFFFF, 0);
      for (int i = 0; i < 16; i++) begin
        m_ready = (i % 4 == 0) || (i % 4 == 3);
        @(posedge clk) #1;
      end
    join
    m_ready = 1;
    drain();
    sel_msb = 1;
    send(W1, 16'hFFFF, 1);
    drain();
    b0 = beats_seen;
    send(W1, 16'hFF00, 1);
    drain();
`ifdef GBX_KEEP_TRIM_EN
    chk("msb_trim_beats", 64'(beats_seen - b0), 2);
`else
    chk("msb_trim_beats", 64'(beats_seen - b0), 4);
`endif
    sel_msb = 0;
    b0 = beats_seen;
    send(W1, 16'h00FF, 1);
    drain();
`ifdef GBX_KEEP_TRIM_EN
    chk("trim_beats", 64'(beats_seen - b0), 2);
`else
    chk("trim_beats", 64'(beats_seen - b0), 4);
`endif
    b0 = beats_seen;
    send(W1, 16'h0000, 1);
    drain();
`ifdef GBX_KEEP_TRIM_EN
    chk("zero_keep_beats", 64'(beats_seen - b0), 1);
`else
    chk("zero_keep_beats", 64'(beats_seen - b0), 4);
`endif
    b0 = beats_seen;
    send(128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 16'hFFFF, 1);
    n = 0;
    while (beats_seen < b0 + 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_wait", 64'(beats_seen - b0), 2);
    rst_n = 0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ready", o_ready, 1);
    q.delete();
    @(posedge clk) #1;
    rst_n = 1;
    @(posedge clk) #1;
    chk("post_rst_valid", o_valid, 0);
    send(128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 16'hFFFF, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
